fir_stream_driver: RTL and testbench
====================================

// Module: fir_stream_driver
// PURPOSE
//  Transmit side of the FIR load interface: drives coefficients, then data samples, then the stop
//  flag into an n-tap FIR filter. Holds a host-writable coefficient bank, accepts upstream samples
//  on a valid/ready handshake and sequences one filter frame per start pulse.
// PARAMETERS
//  LENGTH       20  number of FIR taps / coefficients sent per frame
//  DATA_WIDTH   8   signed coefficient and sample width
//  NUM_SAMPLES  64  samples forwarded per frame (>=1)
// PORTS
//  clock               in   1           rising-edge clock
//  resetN              in   1           asynchronous active-low reset
//  start               in   1           begin frame; sampled only in IDLE
//  coeffWrEn           in   1           coefficient bank write strobe; honoured only in IDLE
//  coeffWrAddr         in   clog2(LEN)  bank address 0..LENGTH-1; out-of-range writes dropped
//  coeffWrData         in   DATA_WIDTH  signed coefficient
//  sampleIn            in   DATA_WIDTH  signed upstream sample
//  sampleValid         in   1           sampleIn valid
//  sampleReady         out  1           driver accepts sample this cycle
//  coefficientOut      out  DATA_WIDTH  coefficient to FIR
//  coefficientsSetFlag out  1           high with the last coefficient
//  dataOut             out  DATA_WIDTH  sample to FIR
//  loadDataFlag        out  1           dataOut valid this cycle
//  stopDataLoadFlag    out  1           one-cycle end-of-frame pulse
//  busy                out  1           state != IDLE
//  done                out  1           one-cycle pulse, same cycle as stopDataLoadFlag
// BEHAVIOUR
//  Reset (async assert, sync release): every output 0, state IDLE, coefficient bank cleared to 0.
//  FSM: IDLE -> SEND_COEFF -> SEND_DATA -> [FLUSH] -> STOP -> IDLE. Undefined encodings -> IDLE.
//  IDLE: start=1 -> SEND_COEFF next cycle. Writes in the same cycle as start are committed first.
//  SEND_COEFF: LENGTH cycles; coefficientOut = bank[0], bank[1] .. bank[LENGTH-1] on consecutive
//   cycles (registered). coefficientsSetFlag=1 only with bank[LENGTH-1]; FIR shift-register ends
//   with the last LENGTH values, so leading cycles lost to FIR idling are harmless.
//  SEND_DATA: sampleReady = (state==SEND_DATA), combinational from state. Beat = valid && ready.
//   Each beat: dataOut <= sampleIn, loadDataFlag <= 1 (1-cycle latency); no beat -> loadDataFlag 0,
//   dataOut holds. Beat counter 0..NUM_SAMPLES-1; the NUM_SAMPLES-th beat exits the state;
//   sampleReady drops the following cycle. No backpressure from FIR side.
//  STOP: stopDataLoadFlag=1 and done=1 for exactly one cycle, then IDLE; loadDataFlag=0 there.
//  start, coeffWrEn while busy: ignored (no queueing). coefficientOut holds last value outside
//   SEND_COEFF; coefficientsSetFlag 0 outside its cycle.
//  Reset mid-frame: outputs 0 immediately; next start replays the full frame (coefficients reloaded).
//  Counters sized clog2(LENGTH) and clog2(NUM_SAMPLES+1); no wrap within a frame.
// CONFIGURATION
//  FIR_DRIVER_FLUSH_EN defined: after SEND_DATA, state FLUSH drives LENGTH-1 beats of dataOut=0
//   with loadDataFlag=1 on consecutive cycles (sampleReady=0), pushing the FIR tail out, then STOP.
//  Undefined: SEND_DATA -> STOP directly; stopDataLoadFlag follows the last data beat by 1 cycle.
// STRUCTURE
//  Shared definitions header fir_defs.vh: FSM state localparams (3-bit), CLOG2 width macro,
//   default LENGTH/DATA_WIDTH shared with the FIR filter.
//  Sub-module fir_coeff_bank: LENGTH x DATA_WIDTH register file, async-clear, one write port,
//   one combinational read port indexed by the SEND_COEFF counter.
// TESTING (bench LENGTH=4, NUM_SAMPLES=8, DATA_WIDTH=8)
//  Reset asserted mid-cycle -> all outputs 0 asynchronously; busy=0 after release.
//  Write 1,2,3,4 to addr 0..3, start -> coefficientOut 1,2,3,4 on 4 consecutive cycles,
//   coefficientsSetFlag high only with 4.
//  Continuous valid, samples 10..17 -> dataOut 10..17 one cycle after each beat, 8 loadDataFlag
//   pulses, sampleReady low after 8th; stop+done single pulse.
//  sampleValid toggling 1,0,1,0.. -> loadDataFlag only after accepted beats, frame still ends
//   after exactly 8 samples; start and coeffWrEn during frame have no effect (bank readback same).
//  FIR_DRIVER_FLUSH_EN on: 3 zero beats after sample 17 before stop; off: stop 1 cycle after 17.
//  resetN low after 3 samples -> outputs 0, IDLE; new start sends coefficients 0,0,0,0.

Source files
------------

// File: rtl/fir_stream_driver_pkg.sv
// Shared definitions for the FIR stream driver: default sizing shared with
// the FIR filter, the driver FSM state encoding and an index-width helper.
package fir_stream_driver_pkg;

    localparam int DEF_LENGTH      = 20;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_NUM_SAMPLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_COEFF = 3'd1,
        ST_SEND_DATA  = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_STOP       = 3'd4
    } drv_state_e;

    // Width of an index able to address 'depth' entries; never below one bit.
    function automatic int idx_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file for the FIR stream driver: LENGTH entries,
// cleared asynchronously, one write port, one combinational read port.
// Writes to addresses at or beyond LENGTH are silently dropped.
module fir_coeff_bank
    import fir_stream_driver_pkg::*;
#(
    parameter int LENGTH     = DEF_LENGTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AW         = idx_width(LENGTH)
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]                rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] bank_q [LENGTH];
    logic signed [DATA_WIDTH-1:0] bank_d [LENGTH];

    // Next bank contents: apply an in-range write, otherwise hold.
    always_comb begin
        bank_d = bank_q;
        if (wr_en && (int'(wr_addr) < LENGTH)) begin
            bank_d[wr_addr] = wr_data;
        end else begin
            bank_d = bank_q;
        end
    end

    // Bank storage with asynchronous clear to zero.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < LENGTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rd_data = bank_q[rd_addr];

endmodule

// File: rtl/fir_stream_driver.sv
// Transmit side of the FIR load interface. One frame per start pulse:
// LENGTH coefficients from the bank, NUM_SAMPLES handshaken samples, an
// optional zero-sample tail, then a one-cycle stop/done pulse.
// Optional feature macro: FIR_DRIVER_FLUSH_EN -- when defined, LENGTH-1 zero
// samples are pushed after the last real sample to drain the FIR tail.
module fir_stream_driver
    import fir_stream_driver_pkg::*;
#(
    parameter int LENGTH      = DEF_LENGTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           start,
    input  logic                           coeffWrEn,
    input  logic [idx_width(LENGTH)-1:0]   coeffWrAddr,
    input  logic signed [DATA_WIDTH-1:0]   coeffWrData,
    input  logic signed [DATA_WIDTH-1:0]   sampleIn,
    input  logic                           sampleValid,
    output logic                           sampleReady,
    output logic signed [DATA_WIDTH-1:0]   coefficientOut,
    output logic                           coefficientsSetFlag,
    output logic signed [DATA_WIDTH-1:0]   dataOut,
    output logic                           loadDataFlag,
    output logic                           stopDataLoadFlag,
    output logic                           busy,
    output logic                           done
);

    localparam int CW  = idx_width(LENGTH);
    localparam int DCW = idx_width(NUM_SAMPLES + 1);

    localparam logic [CW-1:0]  LAST_COEFF  = CW'(LENGTH - 1);
    localparam logic [DCW-1:0] LAST_SAMPLE = DCW'(NUM_SAMPLES - 1);
`ifdef FIR_DRIVER_FLUSH_EN
    localparam logic [CW-1:0]  LAST_FLUSH  = CW'(LENGTH - 2);
`endif

    drv_state_e                   state_q, state_d;
    logic [CW-1:0]                ccnt_q, ccnt_d;     // coefficient / flush beat index
    logic [DCW-1:0]               dcnt_q, dcnt_d;     // accepted sample count
    logic signed [DATA_WIDTH-1:0] coeff_out_q, coeff_out_d;
    logic                         coeff_set_q, coeff_set_d;
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         load_q, load_d;
    logic                         stop_q, stop_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;

    logic                         sample_ready_s;
    logic                         beat_s;
    logic                         bank_we_s;
    logic signed [DATA_WIDTH-1:0] bank_rd_data_s;

    assign sample_ready_s = (state_q == ST_SEND_DATA);
    assign beat_s         = sampleValid && sample_ready_s;
    // The bank is only writable while idle, so a frame never sees a torn set.
    assign bank_we_s      = coeffWrEn && (state_q == ST_IDLE);

    fir_coeff_bank #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (CW)
    ) u_bank (
        .clock   (clock),
        .resetN  (resetN),
        .wr_en   (bank_we_s),
        .wr_addr (coeffWrAddr),
        .wr_data (coeffWrData),
        .rd_addr (ccnt_q),
        .rd_data (bank_rd_data_s)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        ccnt_d      = ccnt_q;
        dcnt_d      = dcnt_q;
        coeff_out_d = coeff_out_q;
        coeff_set_d = 1'b0;
        data_out_d  = data_out_q;
        load_d      = 1'b0;
        stop_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ccnt_d = '0;
                dcnt_d = '0;
                if (start) begin
                    state_d = ST_SEND_COEFF;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND_COEFF: begin
                coeff_out_d = bank_rd_data_s;
                if (ccnt_q == LAST_COEFF) begin
                    coeff_set_d = 1'b1;
                    ccnt_d      = '0;
                    state_d     = ST_SEND_DATA;
                end else begin
                    ccnt_d      = ccnt_q + CW'(1);
                end
            end

            ST_SEND_DATA: begin
                if (beat_s) begin
                    data_out_d = sampleIn;
                    load_d     = 1'b1;
                    if (dcnt_q == LAST_SAMPLE) begin
                        dcnt_d = '0;
`ifdef FIR_DRIVER_FLUSH_EN
                        state_d = (LENGTH > 1) ? ST_FLUSH : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q;
                end
            end

`ifdef FIR_DRIVER_FLUSH_EN
            ST_FLUSH: begin
                data_out_d = '0;
                load_d     = 1'b1;
                if (ccnt_q == LAST_FLUSH) begin
                    ccnt_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    ccnt_d  = ccnt_q + CW'(1);
                end
            end
`endif

            ST_STOP: begin
                stop_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                ccnt_d  = '0;
                dcnt_d  = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; all cleared asynchronously.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            ccnt_q      <= '0;
            dcnt_q      <= '0;
            coeff_out_q <= '0;
            coeff_set_q <= 1'b0;
            data_out_q  <= '0;
            load_q      <= 1'b0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ccnt_q      <= ccnt_d;
            dcnt_q      <= dcnt_d;
            coeff_out_q <= coeff_out_d;
            coeff_set_q <= coeff_set_d;
            data_out_q  <= data_out_d;
            load_q      <= load_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign sampleReady         = sample_ready_s;
    assign coefficientOut      = coeff_out_q;
    assign coefficientsSetFlag = coeff_set_q;
    assign dataOut             = data_out_q;
    assign loadDataFlag        = load_q;
    assign stopDataLoadFlag    = stop_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Self-checking bench for fir_stream_driver (LENGTH=4, NUM_SAMPLES=8, DATA_WIDTH=8).
// Directed frame from a vector table, hand-written corner sequences, and
// random traffic checked against a frame-timeline reference model.
module tb_fir_stream_driver;

    localparam int L  = 4;
    localparam int N  = 8;
    localparam int DW = 8;
`ifdef FIR_DRIVER_FLUSH_EN
    localparam int F = L - 1;
`else
    localparam int F = 0;
`endif

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          start = 1'b0;
    logic          coeffWrEn = 1'b0;
    logic [1:0]    coeffWrAddr = 2'd0;
    logic [DW-1:0] coeffWrData = 8'd0;
    logic [DW-1:0] sampleIn = 8'd0;
    logic          sampleValid = 1'b0;
    logic          sampleReady;
    logic [DW-1:0] coefficientOut;
    logic          coefficientsSetFlag;
    logic [DW-1:0] dataOut;
    logic          loadDataFlag;
    logic          stopDataLoadFlag;
    logic          busy;
    logic          done;

    fir_stream_driver #(.LENGTH(L), .DATA_WIDTH(DW), .NUM_SAMPLES(N)) dut (
        .clock               (clock),
        .resetN              (resetN),
        .start               (start),
        .coeffWrEn           (coeffWrEn),
        .coeffWrAddr         (coeffWrAddr),
        .coeffWrData         (coeffWrData),
        .sampleIn            (sampleIn),
        .sampleValid         (sampleValid),
        .sampleReady         (sampleReady),
        .coefficientOut      (coefficientOut),
        .coefficientsSetFlag (coefficientsSetFlag),
        .dataOut             (dataOut),
        .loadDataFlag        (loadDataFlag),
        .stopDataLoadFlag    (stopDataLoadFlag),
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        bit         st;
        bit         vld;
        logic [7:0] smp;
        logic [7:0] e_coeff;
        bit         e_set;
        logic [7:0] e_data;
        bit         e_load;
        bit         e_busy;
        bit         e_ready;
    } vec_t;

    vec_t tbl [16];

    // Reference model: bank contents plus position within the current frame.
    logic [7:0] m_bank [L];
    logic [7:0] m_snap [L];
    bit         m_busy;
    int         m_k, m_acc, m_end;
    logic [7:0] m_coeff, m_data;
    bit         m_set, m_load, m_stop, m_ready;

    int load_cnt;
    int guard;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_co, input logic e_cs,
                              input logic [7:0] e_d, input logic e_ld, input logic e_st,
                              input logic e_bz, input logic e_rd);
        chk({tag, ".coeff"}, 32'(coefficientOut), 32'(e_co));
        chk({tag, ".set"},   32'(coefficientsSetFlag), 32'(e_cs));
        chk({tag, ".data"},  32'(dataOut), 32'(e_d));
        chk({tag, ".load"},  32'(loadDataFlag), 32'(e_ld));
        chk({tag, ".stop"},  32'(stopDataLoadFlag), 32'(e_st));
        chk({tag, ".done"},  32'(done), 32'(e_st));
        chk({tag, ".busy"},  32'(busy), 32'(e_bz));
        chk({tag, ".ready"}, 32'(sampleReady), 32'(e_rd));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < L; i++) begin
            m_bank[i] = 8'd0;
            m_snap[i] = 8'd0;
        end
        m_busy = 0; m_k = 0; m_acc = 0; m_end = -1;
        m_coeff = 8'd0; m_data = 8'd0;
        m_set = 0; m_load = 0; m_stop = 0; m_ready = 0;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    function automatic void model_step();
        m_set = 0; m_load = 0; m_stop = 0;
        if (!m_busy) begin
            if (coeffWrEn) m_bank[coeffWrAddr] = coeffWrData;
            if (start) begin
                m_busy = 1; m_k = 0; m_acc = 0; m_end = -1;
                for (int i = 0; i < L; i++) m_snap[i] = m_bank[i];
            end
        end else begin
            m_k++;
            if (m_k <= L) begin
                m_coeff = m_snap[m_k - 1];
                m_set   = (m_k == L);
            end else if (m_acc < N) begin
                if (sampleValid) begin
                    m_acc++;
                    m_data = sampleIn;
                    m_load = 1;
                    if (m_acc == N) m_end = m_k;
                end
            end else if (m_k <= m_end + F) begin
                m_data = 8'd0;
                m_load = 1;
            end else begin
                m_stop = 1;
                m_busy = 0;
            end
        end
        m_ready = m_busy && (m_k >= L) && (m_acc < N);
    endfunction

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic tick(input string tag);
        model_step();
        cycle();
        check_outs(tag, m_coeff, m_set, m_data, m_load, m_stop, m_busy, m_ready);
    endtask

    task automatic idle_inputs();
        start = 1'b0; coeffWrEn = 1'b0; sampleValid = 1'b0;
    endtask

    initial begin
        // Directed frame: writes 1..4 (last one together with start), samples 10..17.
        for (int i = 0; i < 16; i++) tbl[i] = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            tbl[i].wr = 1; tbl[i].addr = 2'(i); tbl[i].wdata = 8'(i + 1);
        end
        tbl[3].st = 1;
        for (int r = 3; r < 16; r++) tbl[r].e_busy = 1;
        for (int r = 4; r < 8; r++) begin
            tbl[r].e_coeff = 8'(r - 3);
            tbl[r].e_set   = (r == 7);
        end
        for (int r = 7; r < 16; r++) begin
            tbl[r].vld = 1;
            tbl[r].smp = (r <= 8) ? 8'd10 : 8'(10 + r - 8);
        end
        for (int r = 8; r < 16; r++) begin
            tbl[r].e_coeff = 8'd4;
            tbl[r].e_data  = 8'(10 + r - 8);
            tbl[r].e_load  = 1;
        end
        for (int r = 7; r < 15; r++) tbl[r].e_ready = 1;

        // Reset state.
        #2;
        check_outs("reset", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        resetN = 1'b1;
        model_reset();

        for (int r = 0; r < 16; r++) begin
            coeffWrEn = tbl[r].wr; coeffWrAddr = tbl[r].addr; coeffWrData = tbl[r].wdata;
            start = tbl[r].st; sampleValid = tbl[r].vld; sampleIn = tbl[r].smp;
            model_step();
            cycle();
            check_outs($sformatf("vec%0d", r), tbl[r].e_coeff, tbl[r].e_set, tbl[r].e_data,
                       tbl[r].e_load, 1'b0, tbl[r].e_busy, tbl[r].e_ready);
        end

        // Tail: a still-valid sample must not be taken; optional zero beats; stop pulse.
        coeffWrEn = 1'b0; start = 1'b0; sampleValid = 1'b1; sampleIn = 8'd99;
        for (int i = 0; i < F; i++) begin
            model_step(); cycle();
            check_outs($sformatf("flush%0d", i), 8'd4, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        model_step(); cycle();
        check_outs("stop", 8'd4, 1'b0, (F > 0) ? 8'd0 : 8'd17, 1'b0, 1'b1, 1'b0, 1'b0);
        sampleValid = 1'b0;
        model_step(); cycle();
        check_outs("post_stop", 8'd4, 1'b0, (F > 0) ? 8'd0 : 8'd17, 1'b0, 1'b0, 1'b0, 1'b0);

        // Toggling valid, with start and bank writes hammered while busy.
        idle_inputs();
        start = 1'b1;
        tick("tog_start");
        load_cnt = 0;
        guard = 0;
        while (m_busy && guard < 100) begin
            start = 1'b1; coeffWrEn = 1'b1; coeffWrAddr = 2'(guard); coeffWrData = 8'h55;
            sampleValid = (guard % 2 == 0); sampleIn = 8'(20 + guard);
            tick("tog");
            if (loadDataFlag) load_cnt++;
            guard++;
        end
        chk("tog_timeout", 32'(guard < 100), 32'd1);
        chk("tog_loads", 32'(load_cnt - F), 32'(N));
        idle_inputs();
        tick("tog_idle");
        // Bank must still hold 1..4: replay a frame with no writes.
        start = 1'b1;
        tick("rb_start");
        start = 1'b0; sampleValid = 1'b1;
        guard = 0;
        while (m_busy && guard < 100) begin
            sampleIn = 8'($urandom);
            tick("rb");
            guard++;
        end
        chk("rb_timeout", 32'(guard < 100), 32'd1);
        chk("rb_bank3", 32'(coefficientOut), 32'd4);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            coeffWrEn   = $urandom_range(0, 1);
            coeffWrAddr = 2'($urandom_range(0, 3));
            coeffWrData = 8'($urandom);
            start       = ($urandom_range(0, 7) == 0);
            sampleValid = $urandom_range(0, 1);
            sampleIn    = 8'($urandom);
            tick("rnd");
        end

        // Drain, then load 5..8 and reset in the middle of the data phase.
        idle_inputs();
        sampleValid = 1'b1;
        guard = 0;
        while (m_busy && guard < 100) begin
            tick("drain");
            guard++;
        end
        chk("drain_timeout", 32'(guard < 100), 32'd1);
        idle_inputs();
        for (int i = 0; i < L; i++) begin
            coeffWrEn = 1'b1; coeffWrAddr = 2'(i); coeffWrData = 8'(5 + i);
            start = (i == L - 1);
            tick("mr_wr");
        end
        coeffWrEn = 1'b0; start = 1'b0; sampleValid = 1'b1;
        guard = 0;
        while (m_acc < 3 && guard < 50) begin
            sampleIn = 8'(30 + guard);
            tick("mr_run");
            guard++;
        end
        chk("mr_timeout", 32'(guard < 50), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check_outs("mr_async", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        @(negedge clock);
        resetN = 1'b1;
        model_reset();
        tick("mr_idle");
        start = 1'b1;
        tick("mr_restart");
        start = 1'b0; sampleValid = 1'b1;
        guard = 0;
        while (m_busy && guard < 100) begin
            sampleIn = 8'($urandom);
            tick("mr_frame");
            guard++;
        end
        chk("mr_frame_timeout", 32'(guard < 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
